// File: rtl/dma_req_ctrl.sv
// dma_req_ctrl: peripheral-side request sequencer for the PS7 DMAC peripheral
// request interface. Each channel runs an independent transfer of N AXI
// transactions, choosing SINGLE/BURST requests from the FIFO level, tracking
// DMAC completion acknowledges and servicing DMAC flush requests.
module dma_req_ctrl #(
    parameter int NUM_CH       = 1,
    parameter int LEVEL_W      = 8,
    parameter int TXN_W        = 16,
    parameter int BURST_THRESH = 16
) (
    input  logic                      ACLK,
    input  logic                      RSTN,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH*TXN_W-1:0]   txn_count,
    input  logic [NUM_CH*LEVEL_W-1:0] level,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         flushed,
    output logic [NUM_CH-1:0]         err,
    output logic [NUM_CH-1:0]         DRVALID,
    output logic [NUM_CH-1:0]         DRLAST,
    output logic [NUM_CH*2-1:0]       DRTYPE,
    input  logic [NUM_CH-1:0]         DRREADY,
    input  logic [NUM_CH-1:0]         DAVALID,
    output logic [NUM_CH-1:0]         DAREADY,
    input  logic [NUM_CH*2-1:0]       DATYPE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_REQ,
        ST_WAIT_ACK,
        ST_FLUSH
    } state_t;

    localparam logic [1:0] TYPE_SINGLE = 2'b00;
    localparam logic [1:0] TYPE_BURST  = 2'b01;
    localparam logic [1:0] TYPE_FLUSH  = 2'b10;
    localparam logic [1:0] TYPE_RSVD   = 2'b11;

    localparam logic [LEVEL_W-1:0] THRESH    = LEVEL_W'(BURST_THRESH);
    localparam logic [TXN_W-1:0]   TXN_ONE   = TXN_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             state, state_d;
        logic [TXN_W-1:0]   remaining, remaining_d;
        logic [1:0]         req_type, req_type_d;
        logic               busy_q, busy_d;
        logic               done_q, done_d;
        logic               flushed_q, flushed_d;
        logic               err_q, err_d;
        logic               drvalid_q, drvalid_d;
        logic               drlast_q, drlast_d;
        logic [1:0]         drtype_q, drtype_d;
        logic               daready_q, daready_d;

        logic [TXN_W-1:0]   cnt;
        logic [LEVEL_W-1:0] lvl;
        logic [1:0]         atype;
        logic               ack_hs;
        logic               flush_hs;

        assign cnt      = txn_count[c*TXN_W +: TXN_W];
        assign lvl      = level[c*LEVEL_W +: LEVEL_W];
        assign atype    = DATYPE[c*2 +: 2];
        assign ack_hs   = DAVALID[c] & daready_q;
        assign flush_hs = ack_hs & (atype == TYPE_FLUSH);

        // State and registered-output update
        always_ff @(posedge ACLK or negedge RSTN) begin
            if (!RSTN) begin
                state     <= ST_IDLE;
                remaining <= '0;
                req_type  <= TYPE_SINGLE;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                flushed_q <= 1'b0;
                err_q     <= 1'b0;
                drvalid_q <= 1'b0;
                drlast_q  <= 1'b0;
                drtype_q  <= TYPE_SINGLE;
                daready_q <= 1'b0;
            end else begin
                state     <= state_d;
                remaining <= remaining_d;
                req_type  <= req_type_d;
                busy_q    <= busy_d;
                done_q    <= done_d;
                flushed_q <= flushed_d;
                err_q     <= err_d;
                drvalid_q <= drvalid_d;
                drlast_q  <= drlast_d;
                drtype_q  <= drtype_d;
                daready_q <= daready_d;
            end
        end

        // Next-state and next-output decode for one channel
        always_comb begin
            state_d     = state;
            remaining_d = remaining;
            req_type_d  = req_type;
            busy_d      = busy_q;
            done_d      = 1'b0;
            flushed_d   = 1'b0;
            err_d       = err_q;
            drvalid_d   = drvalid_q;
            drlast_d    = drlast_q;
            drtype_d    = drtype_q;

            // DAREADY is high only in IDLE/ARM/WAIT_ACK, so a flush handshake
            // can only occur there; handling it first gives it priority over start.
            if (flush_hs) begin
                remaining_d = '0;
                drvalid_d   = 1'b1;
                drtype_d    = TYPE_FLUSH;
                drlast_d    = 1'b0;
                busy_d      = 1'b1;
                state_d     = ST_FLUSH;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start[c] && (cnt != '0)) begin
                            remaining_d = cnt;
                            err_d       = 1'b0;
                            busy_d      = 1'b1;
                            state_d     = ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (lvl != '0) begin
                            drvalid_d = 1'b1;
                            drtype_d  = (lvl >= THRESH) ? TYPE_BURST : TYPE_SINGLE;
                            drlast_d  = (remaining == TXN_ONE);
                            state_d   = ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (DRREADY[c]) begin
                            req_type_d = drtype_q;
                            drvalid_d  = 1'b0;
                            state_d    = ST_WAIT_ACK;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (ack_hs) begin
                            if (atype == TYPE_RSVD) begin
                                err_d = 1'b1;
                            end else begin
                                remaining_d = remaining - TXN_ONE;
                                if (atype != req_type) begin
                                    err_d = 1'b1;
                                end
                                if (remaining == TXN_ONE) begin
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                    state_d = ST_IDLE;
                                end else begin
                                    state_d = ST_ARM;
                                end
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (DRREADY[c]) begin
                            drvalid_d = 1'b0;
                            flushed_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            daready_d = (state_d == ST_IDLE) || (state_d == ST_ARM) ||
                        (state_d == ST_WAIT_ACK);
        end

        assign busy[c]         = busy_q;
        assign done[c]         = done_q;
        assign flushed[c]      = flushed_q;
        assign err[c]          = err_q;
        assign DRVALID[c]      = drvalid_q;
        assign DRLAST[c]       = drlast_q;
        assign DRTYPE[c*2 +: 2] = drtype_q;
        assign DAREADY[c]      = daready_q;
    end

endmodule
